// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code parser: pops bytes from the receiver FIFO,
// emits key events and keeps a Game Boy joypad pressed-state vector.
module ps2_scancode_decoder #(
    parameter logic [7:0] KEY_A      = 8'h1A,
    parameter logic [7:0] KEY_B      = 8'h22,
    parameter logic [7:0] KEY_SELECT = 8'h59,
    parameter logic [7:0] KEY_START  = 8'h5A,
    parameter int         PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       kb_overflow,
    output logic       kb_rdn,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [7:0] joypad,
    output logic       parse_err
);
    localparam int SW = $clog2(PAUSE_SKIP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_skip;
    logic            r_key_valid;
    logic [7:0]      r_key_code;
    logic            r_key_ext;
    logic            r_key_break;
    logic [7:0]      r_joypad;
    logic            r_parse_err;

    logic            w_pop;
    logic            w_err_byte;
    logic            w_emit;
    logic            w_ext;
    logic            w_brk;
    logic [7:0]      w_mask;

    assign w_pop      = kb_ready & ~rst;
    assign kb_rdn     = ~w_pop;
    assign w_err_byte = (kb_data == 8'h00) || (kb_data == 8'hFF);

    function automatic logic [7:0] f_map(input logic [7:0] code,
                                         input logic       ext);
        logic [7:0] m;
        m = 8'h00;
        if (ext) begin
            unique case (code)
                8'h74:   m = 8'h01;
                8'h6B:   m = 8'h02;
                8'h75:   m = 8'h04;
                8'h72:   m = 8'h08;
                default: m = 8'h00;
            endcase
        end else begin
            if (code == KEY_A)      m = 8'h10;
            if (code == KEY_B)      m = 8'h20;
            if (code == KEY_SELECT) m = 8'h40;
            if (code == KEY_START)  m = 8'h80;
        end
        return m;
    endfunction

    // Which bytes complete an event, and with which flags.
    always_comb begin
        w_emit = 1'b0;
        w_ext  = 1'b0;
        w_brk  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_emit = !(kb_data inside {8'hE0, 8'hF0, 8'hE1,
                                           8'hAA, 8'hFA, 8'hEE, 8'hFE});
            end
            S_EXT: begin
                w_emit = !(kb_data inside {8'hE0, 8'hF0});
                w_ext  = 1'b1;
            end
            S_BRK: begin
                w_emit = !(kb_data inside {8'hE0, 8'hF0});
                w_brk  = 1'b1;
            end
            S_EXTBRK: begin
                w_emit = 1'b1;
                w_ext  = 1'b1;
                w_brk  = 1'b1;
            end
            default: w_emit = 1'b0;
        endcase
        w_mask = f_map(kb_data, w_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_skip      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_break <= 1'b0;
            r_joypad    <= 8'h00;
            r_parse_err <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_parse_err <= 1'b0;
            if (kb_overflow || (w_pop && w_err_byte)) begin
                r_state     <= S_IDLE;
                r_skip      <= '0;
                r_joypad    <= 8'h00;
                r_parse_err <= 1'b1;
            end else if (w_pop) begin
                if (w_emit && r_state != S_SKIP) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= kb_data;
                    r_key_ext   <= w_ext;
                    r_key_break <= w_brk;
                    if (w_brk) r_joypad <= r_joypad & ~w_mask;
                    else       r_joypad <= r_joypad | w_mask;
                end
                unique case (r_state)
                    S_IDLE: begin
                        if (kb_data == 8'hE0) begin
                            r_state <= S_EXT;
                        end else if (kb_data == 8'hF0) begin
                            r_state <= S_BRK;
                        end else if (kb_data == 8'hE1) begin
                            r_state <= S_SKIP;
                            r_skip  <= SW'(PAUSE_SKIP);
                        end
                    end
                    S_EXT: begin
                        if (kb_data == 8'hF0)      r_state <= S_EXTBRK;
                        else if (kb_data != 8'hE0) r_state <= S_IDLE;
                    end
                    S_BRK:    r_state <= S_IDLE;
                    S_EXTBRK: r_state <= S_IDLE;
                    S_SKIP: begin
                        r_skip <= r_skip - 1'b1;
                        if (r_skip <= SW'(1)) r_state <= S_IDLE;
                    end
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_ext   = r_key_ext;
    assign key_break = r_key_break;
    assign joypad    = r_joypad;
    assign parse_err = r_parse_err;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: scan-code sequences with
// hand-computed event, joypad and error expectations.
module tb_ps2_scancode_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_rdn;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] joypad;
    logic       parse_err;

    int checks   = 0;
    int failures = 0;

    ps2_scancode_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .kb_data     (kb_data),
        .kb_ready    (kb_ready),
        .kb_overflow (kb_overflow),
        .kb_rdn      (kb_rdn),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .joypad      (joypad),
        .parse_err   (parse_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event-less byte: no pulse, joypad as given.
    task automatic chk_quiet(input string tag, input logic [7:0] jp);
        chk({tag, ".valid"}, key_valid, 0);
        chk({tag, ".err"}, parse_err, 0);
        chk({tag, ".joy"}, joypad, jp);
    endtask

    task automatic chk_ev(input string tag, input logic [7:0] code,
                          input logic ext, input logic brk,
                          input logic [7:0] jp);
        chk({tag, ".valid"}, key_valid, 1);
        chk({tag, ".code"}, key_code, code);
        chk({tag, ".ext"}, key_ext, ext);
        chk({tag, ".brk"}, key_break, brk);
        chk({tag, ".joy"}, joypad, jp);
        chk({tag, ".err"}, parse_err, 0);
    endtask

    // Present one byte for one cycle; kb_ready stays high afterwards.
    task automatic send(input logic [7:0] b, input logic ovf = 1'b0);
        @(negedge clk);
        kb_data     = b;
        kb_ready    = 1'b1;
        kb_overflow = ovf;
        #1;
        chk("rdn_low", kb_rdn, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        kb_ready    = 1'b0;
        kb_overflow = 1'b0;
        #1;
        chk("rdn_high", kb_rdn, 1);
        @(posedge clk);
        #1;
        chk("idle.valid", key_valid, 0);
        chk("idle.err", parse_err, 0);
    endtask

    initial begin
        rst         = 1'b1;
        kb_data     = 8'h1A;
        kb_ready    = 1'b1;
        kb_overflow = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.rdn", kb_rdn, 1);
        @(posedge clk);
        #1;
        chk("rst.valid", key_valid, 0);
        chk("rst.code", key_code, 8'h00);
        chk("rst.ext", key_ext, 0);
        chk("rst.brk", key_break, 0);
        chk("rst.joy", joypad, 8'h00);
        chk("rst.err", parse_err, 0);
        @(negedge clk);
        kb_ready = 1'b0;
        rst      = 1'b0;

        // Z make then break
        idle();
        send(8'h1A); chk_ev("z_make", 8'h1A, 0, 0, 8'h10);
        idle();
        send(8'hF0); chk_quiet("z_f0", 8'h10);
        idle();
        send(8'h1A); chk_ev("z_brk", 8'h1A, 0, 1, 8'h00);
        idle();

        // Typematic repeat and ignored codes
        send(8'h1A); chk_ev("rep1", 8'h1A, 0, 0, 8'h10);
        send(8'h1A); chk_ev("rep2", 8'h1A, 0, 0, 8'h10);
        send(8'hAA); chk_quiet("ign_aa", 8'h10);
        send(8'hF0); chk_quiet("rep_f0", 8'h10);
        send(8'h1A); chk_ev("rep_brk", 8'h1A, 0, 1, 8'h00);
        idle();

        // Arrows
        send(8'hE0); chk_quiet("up_e0", 8'h00);
        send(8'h75); chk_ev("up", 8'h75, 1, 0, 8'h04);
        send(8'hE0); chk_quiet("rt_e0", 8'h04);
        send(8'h74); chk_ev("right", 8'h74, 1, 0, 8'h05);
        send(8'hE0); chk_quiet("upb_e0", 8'h05);
        send(8'hF0); chk_quiet("upb_f0", 8'h05);
        send(8'h75); chk_ev("up_brk", 8'h75, 1, 1, 8'h01);
        send(8'h74); chk_ev("74_noext", 8'h74, 0, 0, 8'h01);
        send(8'hE0); send(8'hF0);
        send(8'h74); chk_ev("rt_brk", 8'h74, 1, 1, 8'h00);
        idle();

        // Back-to-back: 5 pops, 4 events
        send(8'h5A); chk_ev("b2b_start", 8'h5A, 0, 0, 8'h80);
        send(8'h22); chk_ev("b2b_b", 8'h22, 0, 0, 8'hA0);
        send(8'hF0); chk_quiet("b2b_f0", 8'hA0);
        send(8'h5A); chk_ev("b2b_startb", 8'h5A, 0, 1, 8'h20);
        send(8'h59); chk_ev("b2b_sel", 8'h59, 0, 0, 8'h60);
        idle();

        // Pause sequence skipped
        send(8'hE1); chk_quiet("p_e1", 8'h60);
        send(8'h14); chk_quiet("p_14", 8'h60);
        send(8'h77); chk_quiet("p_77", 8'h60);
        send(8'hE1); chk_quiet("p_e1b", 8'h60);
        send(8'hF0); chk_quiet("p_f0", 8'h60);
        send(8'h14); chk_quiet("p_14b", 8'h60);
        send(8'hF0); chk_quiet("p_f0b", 8'h60);
        send(8'h77); chk_quiet("p_77b", 8'h60);
        send(8'h1A); chk_ev("p_after", 8'h1A, 0, 0, 8'h70);
        idle();

        // Build joypad = 90
        send(8'hF0); send(8'h22); chk_ev("bb", 8'h22, 0, 1, 8'h50);
        send(8'hF0); send(8'h59); chk_ev("sb", 8'h59, 0, 1, 8'h10);
        send(8'h5A); chk_ev("st", 8'h5A, 0, 0, 8'h90);
        idle();

        // Overflow pulse with no byte
        @(negedge clk);
        kb_overflow = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf.joy", joypad, 8'h00);
        chk("ovf.err", parse_err, 1);
        chk("ovf.valid", key_valid, 0);
        idle();
        send(8'h1A); chk_ev("ovf_idle", 8'h1A, 0, 0, 8'h10);
        send(8'hE0); chk_quiet("ff_e0", 8'h10);
        send(8'hFF);
        chk("ff.err", parse_err, 1);
        chk("ff.valid", key_valid, 0);
        chk("ff.joy", joypad, 8'h00);
        send(8'h75); chk_ev("ff_idle", 8'h75, 0, 0, 8'h00);
        idle();

        // Overflow wins over a simultaneous byte
        send(8'h5A); chk_ev("pre_ovf", 8'h5A, 0, 0, 8'h80);
        send(8'h1A, 1'b1);
        chk("ovfb.err", parse_err, 1);
        chk("ovfb.valid", key_valid, 0);
        chk("ovfb.joy", joypad, 8'h00);
        idle();

        // Error aborts SKIP
        send(8'hE1); send(8'h14);
        send(8'h00);
        chk("skip00.err", parse_err, 1);
        send(8'h1A); chk_ev("skip_abort", 8'h1A, 0, 0, 8'h10);
        idle();

        // Reset mid-sequence
        send(8'hE0); send(8'hF0);
        @(negedge clk);
        kb_ready = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst.joy", joypad, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        send(8'h75); chk_ev("post_rst", 8'h75, 0, 0, 8'h00);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
